// File: rtl/prng_stream_pkg.sv
// Shared types and constants for the PRNG request/stream controller.
// Optional checker build: define PRNG_STREAM_CHK_EN (see prng_stream_ctrl.sv).
package prng_stream_pkg;
   localparam int CNT_W_DEF   = 32;
   localparam int PRNG_WORD_W = 256;
   localparam int PREFIX_W    = 7;
   // Width of the counter that swallows results of requests issued before a reset.
   localparam int IGN_W       = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/prng_stream_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// The head word is read straight from the storage registers, so a pushed word
// is visible at dout one cycle after the push. Push and pop may coincide, also
// when full (the pop frees the slot) and when empty (the pop is ignored).
module prng_stream_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 256,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/prng_stream_ctrl.sv
// Request/stream controller around the counter-mode PRNG stage.
// Issues counter values to the PRNG only against reserved buffer space
// (credit = fifo_count + inflight < FIFO_DEPTH) and streams results out.
// Optional checker build: define PRNG_STREAM_CHK_EN to make err flag
// overflowing pushes and unsolicited PRNG results; otherwise err is 0.
module prng_stream_ctrl
   import prng_stream_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   start,
   input  logic [31:0]            num_blocks,
   input  logic [CNT_W-1:0]       cnt_base,
   input  logic [PREFIX_W-1:0]    prefix_in,
   output logic                   busy,
   output logic                   done,
   output logic [PREFIX_W-1:0]    prng_prefix,
   output logic [CNT_W-1:0]       prng_cnt,
   output logic                   prng_drdy,
   input  logic [PRNG_WORD_W-1:0] prng_dout,
   input  logic                   prng_dvld,
   output logic [PRNG_WORD_W-1:0] rnd_data,
   output logic                   rnd_valid,
   input  logic                   rnd_ready,
   output logic                   err
);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int CW1 = CW + 1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      remaining;
   logic [31:0]      popped;
   logic [31:0]      nblk;
   logic [CW-1:0]    inflight;
   logic [CW-1:0]    fifo_count;
   logic [CW:0]      credit_used;
   logic [IGN_W-1:0] ignore_cnt;
   logic             issue;
   logic             push;
   logic             pop;
   logic             drop;
   logic             retire;

   // Output stream: a word transfers on every cycle where rnd_valid and
   // rnd_ready are both high; rnd_valid never depends on rnd_ready and the
   // head word stays stable until it is transferred.
   assign pop         = rnd_valid & rnd_ready;
   assign drop        = prng_dvld && (ignore_cnt != '0);
   assign push        = prng_dvld && (ignore_cnt == '0);
   assign retire      = push && (inflight != '0);
   assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
   assign issue       = (state == ST_ISSUE) && (remaining != '0) &&
                        (credit_used < CW1'(FIFO_DEPTH));
   assign rnd_valid   = (fifo_count != '0);

   prng_stream_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PRNG_WORD_W)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (push),
      .din   (prng_dout),
      .pop   (pop),
      .dout  (rnd_data),
      .count (fifo_count)
   );

   // Run FSM with issue counter, credit tracking and stale-result filter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         prng_drdy   <= 1'b0;
         prng_cnt    <= '0;
         prng_prefix <= '0;
         cnt         <= '0;
         remaining   <= '0;
         popped      <= '0;
         nblk        <= '0;
         inflight    <= '0;
         // Everything still inside the PRNG pipeline must be discarded later;
         // a result landing in this very cycle is already accounted for.
         ignore_cnt  <= ignore_cnt + IGN_W'(inflight) - IGN_W'(drop || retire);
      end else begin
         done      <= 1'b0;
         prng_drdy <= issue;
         if (issue) begin
            prng_cnt  <= cnt;
            cnt       <= cnt + CNT_W'(1);
            remaining <= remaining - 32'd1;
         end
         if (drop) ignore_cnt <= ignore_cnt - IGN_W'(1);
         inflight <= inflight + CW'(issue) - CW'(retire);
         if (pop && (state != ST_IDLE)) popped <= popped + 32'd1;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (num_blocks != '0) begin
                     cnt         <= cnt_base;
                     prng_prefix <= prefix_in;
                     remaining   <= num_blocks;
                     nblk        <= num_blocks;
                     popped      <= '0;
                     busy        <= 1'b1;
                     state       <= ST_ISSUE;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (issue && (remaining == 32'd1)) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pop && (popped == nblk - 32'd1)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef PRNG_STREAM_CHK_EN
   // Sticky protocol error: overflowing push or a result nobody asked for.
   always_ff @(posedge CLK) begin
      if (RST) begin
         err <= 1'b0;
      end else if ((push && (fifo_count == CW'(FIFO_DEPTH)) && !pop) ||
                   (push && (inflight == '0))) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_prng_stream_ctrl.sv
// Directed bench for prng_stream_ctrl with a latency-5 PRNG model.
module tb_prng_stream_ctrl;
   localparam int LAT = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [31:0]  num_blocks = '0;
   logic [31:0]  cnt_base = '0;
   logic [6:0]   prefix_in = '0;
   logic         busy, done, prng_drdy, rnd_valid, err;
   logic [6:0]   prng_prefix;
   logic [31:0]  prng_cnt;
   logic [255:0] prng_dout, rnd_data;
   logic         prng_dvld;
   logic         rnd_ready = 1'b0;
   logic         inj_vld = 1'b0;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int cyc = 0;
   logic [255:0] exp_q[$];
   logic [31:0]  issue_log[$];
   int           issue_cyc[$];

   typedef struct {
      logic [31:0] nb;
      logic [31:0] base;
      logic [6:0]  pfx;
      int          hold;
      logic        consec;
      logic [31:0] exp_last;
      int          exp_hold_issues;
   } vec_t;

   prng_stream_ctrl #(.FIFO_DEPTH(8), .CNT_W(32)) dut (
      .CLK(clk), .RST(rst), .start(start), .num_blocks(num_blocks),
      .cnt_base(cnt_base), .prefix_in(prefix_in), .busy(busy), .done(done),
      .prng_prefix(prng_prefix), .prng_cnt(prng_cnt), .prng_drdy(prng_drdy),
      .prng_dout(prng_dout), .prng_dvld(prng_dvld), .rnd_data(rnd_data),
      .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .err(err)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] model_word(input logic [31:0] c, input logic [6:0] p);
      logic [255:0] w;
      for (int i = 0; i < 8; i++) w[i*32 +: 32] = c ^ {p, 25'd0} ^ (32'h9E37_79B9 * 32'(i + 1));
      return w;
   endfunction

   // PRNG model: fixed latency, no reset, no backpressure
   logic        pipe_v [LAT];
   logic [31:0] pipe_c [LAT];
   logic [6:0]  pipe_p [LAT];
   initial for (int i = 0; i < LAT; i++) begin pipe_v[i] = 1'b0; pipe_c[i] = '0; pipe_p[i] = '0; end
   always @(posedge clk) begin
      pipe_v[0] <= prng_drdy;
      pipe_c[0] <= prng_cnt;
      pipe_p[0] <= prng_prefix;
      for (int i = 1; i < LAT; i++) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_c[i] <= pipe_c[i-1];
         pipe_p[i] <= pipe_p[i-1];
      end
   end
   assign prng_dvld = pipe_v[LAT-1] | inj_vld;
   assign prng_dout = model_word(pipe_c[LAT-1], pipe_p[LAT-1]);

   task automatic check_eq(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h", name, act, req);
      end
   endtask

   // Monitor / scoreboard on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         if (prng_drdy) begin
            issue_log.push_back(prng_cnt);
            issue_cyc.push_back(cyc);
         end
         if (rnd_valid && rnd_ready) begin
            if (exp_q.size() == 0) check_eq("unexpected_word", rnd_data, '0);
            else check_eq("rnd_data", rnd_data, exp_q.pop_front());
         end
         if (done) begin
            done_cnt++;
            check_eq("busy_with_done", 256'(busy), 256'(0));
         end
      end
   end

   // Driver tasks: entered and left at posedge+1
   task automatic pulse_start(input logic [31:0] nb, input logic [31:0] base, input logic [6:0] pfx);
      start = 1'b1; num_blocks = nb; cnt_base = base; prefix_in = pfx;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      for (int k = 0; k < budget && done_cnt == d0; k++) @(posedge clk);
      #1;
      if (done_cnt == d0) check_eq("done_timeout", 256'(done_cnt), 256'(d0 + 1));
   endtask

   task automatic load_exp(input logic [31:0] nb, input logic [31:0] base, input logic [6:0] pfx);
      for (int k = 0; k < int'(nb); k++) exp_q.push_back(model_word(base + 32'(k), pfx));
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int d0;
      issue_log.delete(); issue_cyc.delete();
      load_exp(v.nb, v.base, v.pfx);
      rnd_ready = (v.hold == 0);
      d0 = done_cnt;
      pulse_start(v.nb, v.base, v.pfx);
      check_eq($sformatf("v%0d_busy_rise", idx), 256'(busy), 256'(1));
      if (v.hold > 0) begin
         repeat (v.hold) @(posedge clk);
         #1;
         check_eq($sformatf("v%0d_hold_issues", idx), 256'(issue_log.size()), 256'(v.exp_hold_issues));
         check_eq($sformatf("v%0d_hold_drdy", idx), 256'(prng_drdy), 256'(0));
         rnd_ready = 1'b1;
      end
      wait_done(d0, 600);
      repeat (3) @(posedge clk);
      #1;
      check_eq($sformatf("v%0d_issue_count", idx), 256'(issue_log.size()), 256'(v.nb));
      if (issue_log.size() > 0) begin
         check_eq($sformatf("v%0d_first_cnt", idx), 256'(issue_log[0]), 256'(v.base));
         check_eq($sformatf("v%0d_last_cnt", idx), 256'(issue_log[issue_log.size()-1]), 256'(v.exp_last));
         if (v.consec)
            check_eq($sformatf("v%0d_consec", idx),
                     256'(issue_cyc[issue_cyc.size()-1] - issue_cyc[0]), 256'(v.nb - 1));
      end
      check_eq($sformatf("v%0d_done_pulses", idx), 256'(done_cnt - d0), 256'(1));
      check_eq($sformatf("v%0d_words_left", idx), 256'(exp_q.size()), 256'(0));
      check_eq($sformatf("v%0d_busy_end", idx), 256'(busy), 256'(0));
      check_eq($sformatf("v%0d_err", idx), 256'(err), 256'(0));
   endtask

   // Watchdog
   initial begin
      #400000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[4];
      int   d0;
      int   n;
      vecs[0] = '{nb: 32'd4,  base: 32'h10,         pfx: 7'h2A, hold: 0,  consec: 1'b1, exp_last: 32'h13,       exp_hold_issues: 0};
      vecs[1] = '{nb: 32'd3,  base: 32'hFFFF_FFFE, pfx: 7'h01, hold: 0,  consec: 1'b1, exp_last: 32'h0000_0000, exp_hold_issues: 0};
      vecs[2] = '{nb: 32'd1,  base: 32'h55,         pfx: 7'h7F, hold: 0,  consec: 1'b1, exp_last: 32'h55,       exp_hold_issues: 0};
      vecs[3] = '{nb: 32'd20, base: 32'h200,        pfx: 7'h11, hold: 40, consec: 1'b0, exp_last: 32'h213,      exp_hold_issues: 8};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 256'(busy), 256'(0));
      check_eq("rst_done", 256'(done), 256'(0));
      check_eq("rst_drdy", 256'(prng_drdy), 256'(0));
      check_eq("rst_cnt", 256'(prng_cnt), 256'(0));
      check_eq("rst_prefix", 256'(prng_prefix), 256'(0));
      check_eq("rst_valid", 256'(rnd_valid), 256'(0));
      check_eq("rst_err", 256'(err), 256'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Table-driven runs
      for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

      // Zero-length run: done next cycle, no issue, busy stays low
      issue_log.delete();
      d0 = done_cnt;
      pulse_start(32'd0, 32'h77, 7'h01);
      check_eq("zero_done", 256'(done), 256'(1));
      check_eq("zero_busy", 256'(busy), 256'(0));
      repeat (5) @(posedge clk);
      #1;
      check_eq("zero_issues", 256'(issue_log.size()), 256'(0));
      check_eq("zero_done_pulses", 256'(done_cnt - d0), 256'(1));

      // Second start while busy is ignored
      issue_log.delete();
      load_exp(32'd6, 32'h300, 7'h33);
      rnd_ready = 1'b1;
      d0 = done_cnt;
      pulse_start(32'd6, 32'h300, 7'h33);
      @(posedge clk); #1;
      pulse_start(32'd2, 32'h900, 7'h44);
      wait_done(d0, 600);
      repeat (3) @(posedge clk);
      #1;
      check_eq("busy_start_issues", 256'(issue_log.size()), 256'(6));
      if (issue_log.size() > 0)
         check_eq("busy_start_last", 256'(issue_log[issue_log.size()-1]), 256'(32'h305));
      check_eq("busy_start_done", 256'(done_cnt - d0), 256'(1));
      check_eq("busy_start_words_left", 256'(exp_q.size()), 256'(0));

      // Reset with three requests in flight; stale results must vanish
      rnd_ready = 1'b0;
      pulse_start(32'd10, 32'h40, 7'h0C);
      n = 0;
      for (int k = 0; k < 50 && n < 3; k++) begin
         @(posedge clk); #1;
         if (prng_drdy) n++;
      end
      check_eq("inflight_reached", 256'(n), 256'(3));
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      check_eq("midrst_busy", 256'(busy), 256'(0));
      check_eq("midrst_valid", 256'(rnd_valid), 256'(0));
      check_eq("midrst_drdy", 256'(prng_drdy), 256'(0));
      rst = 1'b0;
      issue_log.delete();
      load_exp(32'd4, 32'h100, 7'h05);
      rnd_ready = 1'b1;
      d0 = done_cnt;
      pulse_start(32'd4, 32'h100, 7'h05);
      wait_done(d0, 600);
      repeat (LAT + 3) @(posedge clk);
      #1;
      check_eq("stale_words_left", 256'(exp_q.size()), 256'(0));
      check_eq("stale_valid_after", 256'(rnd_valid), 256'(0));
      if (issue_log.size() > 0) check_eq("stale_first_cnt", 256'(issue_log[0]), 256'(32'h100));
      check_eq("stale_err", 256'(err), 256'(0));

`ifdef PRNG_STREAM_CHK_EN
      // Unsolicited result while idle sets a sticky error
      rnd_ready = 1'b0;
      inj_vld = 1'b1;
      @(posedge clk); #1;
      inj_vld = 1'b0;
      check_eq("chk_err_set", 256'(err), 256'(1));
      repeat (5) @(posedge clk);
      #1;
      check_eq("chk_err_held", 256'(err), 256'(1));
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("chk_err_cleared", 256'(err), 256'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/prng_stream_ctrl.md
Name: prng_stream_ctrl

Overview:
- Request/stream controller sitting directly around the 256-bit counter-mode PRNG stage. It drives that stage's counter, prefix and Drdy inputs, and captures its Dout/Dvld results.
- The PRNG pipeline has no backpressure, so this block issues requests only when buffer space is reserved (credit scheme). It presents the buffered 256-bit random words downstream on a valid/ready stream.
- Sits between the correlated-randomness consumer and the AES-based PRNG.

Parameters:
- FIFO_DEPTH, 8, number of 256-bit entries in the result buffer (power of two, >= 2)
- CNT_W, 32, counter width; must match the PRNG cnt input

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- start  in  1  one-cycle request to begin a run; ignored while busy=1
- num_blocks  in  32  number of 256-bit words in the run; sampled on accepted start
- cnt_base  in  CNT_W  first counter value; sampled on accepted start
- prefix_in  in  7  domain-separation prefix; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last word of the run is popped downstream
- prng_prefix  out  7  registered prefix to PRNG
- prng_cnt  out  CNT_W  counter to PRNG, valid when prng_drdy=1
- prng_drdy  out  1  issue strobe to PRNG, at most one per cycle
- prng_dout  in  256  PRNG result
- prng_dvld  in  1  PRNG result valid
- rnd_data  out  256  FIFO head word
- rnd_valid  out  1  FIFO not empty
- rnd_ready  in  1  downstream accept; a pop occurs when rnd_valid & rnd_ready
- err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset values: busy=0, done=0, prng_drdy=0, prng_cnt=0, prng_prefix=0, rnd_valid=0, err=0. FIFO is emptied, credits are cleared, and the FSM goes to IDLE. Reset mid-run abandons the run.
  - PRNG results arriving after reset from pre-reset requests are dropped: an ignore counter is loaded with the in-flight count at reset and decremented on each dvld.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - On start with num_blocks>0: latch inputs, set remaining=num_blocks and popped=0, go to ISSUE; busy=1 next cycle.
  - On start with num_blocks=0: done pulses the next cycle, busy stays 0, no issue.
- ISSUE:
  - Issue rule: prng_drdy=1 in a cycle iff remaining>0 and (fifo_count + inflight) < FIFO_DEPTH.
  - On each issue: prng_cnt=current counter, then counter+1 (wraps mod 2^CNT_W, no error), remaining-1, inflight+1.
  - When remaining reaches 0, go to DRAIN.
- Credit accounting:
  - inflight increments on issue and decrements on prng_dvld.
  - Simultaneous issue and dvld leaves inflight unchanged.
  - prng_dvld pushes prng_dout into the FIFO the same cycle; a push is always guaranteed space by the credit.
- FIFO:
  - Registered read-data-at-head (first-word-fall-through).
  - Push and pop in the same cycle are both allowed, including when full (pop frees the space) and when empty (push only).
  - Push-to-rnd_valid latency is 1 cycle. Output words appear in issue (counter) order.
- DRAIN: when popped == num_blocks, assert done for 1 cycle, busy=0, go to IDLE. Issue-to-output latency is PRNG latency + 1 cycle.
- Throughput: one word per cycle sustained when rnd_ready is held high.

Optional Feature:
- Macro PRNG_STREAM_CHK_EN.
- Defined: err is set and held until RST on any of the following:
  - push while FIFO full;
  - prng_dvld while inflight=0 (and the ignore counter is 0);
  - pop while empty is impossible by construction, so it is not checked.
- Not defined: err is tied to 0 and the checking logic is absent.

Decomposition:
- Package prng_stream_pkg: CNT_W default, PRNG_WORD_W=256, PREFIX_W=7, FSM state enum typedef.
- One sub-module, prng_stream_fifo: synchronous FIFO with count output, parameterised by depth and width.
- FSM, counters and credit logic stay in the top module.

Test Plan:
- Reset, then start with num_blocks=4, cnt_base=0x10, prefix=0x2A, model latency 5, rnd_ready=1 -> prng_cnt 0x10..0x13 on 4 consecutive cycles; rnd_data equals model output for 0x10..0x13 in order; one done pulse; busy falls with done.
- num_blocks=20, FIFO_DEPTH=8, rnd_ready=0 for 40 cycles -> exactly 8 issues, then prng_drdy stays 0. After rnd_ready=1, the remaining 12 issue and all 20 words arrive in order.
- cnt_base=0xFFFFFFFE, num_blocks=3 -> prng_cnt sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; err stays 0.
- start with num_blocks=0 -> done one cycle later, prng_drdy never asserted; a second start while busy is ignored (counter not reloaded).
- RST asserted with 3 words in flight, then new run with cnt_base=0x100 -> the 3 stale dvld results are dropped; the first rnd_data corresponds to cnt 0x100.
- With PRNG_STREAM_CHK_EN defined, inject a spurious prng_dvld while idle -> err=1 next cycle and held until RST.
